// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target.sv
// Next-PC select: the sequential step or the taken-redirect target.
// Relative targets are base + imm with natural wrap. Absolute targets
// clear only bit 0, so bit 1 passes through and no alignment trap exists.
module pc_target
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect_valid,
    input  logic             redirect_abs,
    input  logic [WIDTH-1:0] redirect_base,
    input  logic [WIDTH-1:0] redirect_imm,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] seq_pc_s;
    logic [WIDTH-1:0] redir_pc_s;

    // Compute both candidates and pick the redirect when one is taken.
    always_comb begin
        seq_pc_s = pc + WIDTH'(PC_INC);
        if (redirect_abs) begin
            redir_pc_s = {redirect_imm[WIDTH-1:1], 1'b0};
        end else begin
            redir_pc_s = redirect_base + redirect_imm;
        end
        if (redirect_valid) begin
            next_pc = redir_pc_s;
        end else begin
            next_pc = seq_pc_s;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight, buffers
// the returned instruction for decode and kills fetches made stale by a
// redirect. Only if_valid is combinational (masked by redirect_valid).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic               redirect_abs,
    input  logic [WIDTH-1:0]   redirect_base,
    input  logic [WIDTH-1:0]   redirect_imm,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [WIDTH-1:0]   if_pc
);

    fetch_state_t       state_r;
    logic [WIDTH-1:0]   pc_r;
    logic [WIDTH-1:0]   next_pc_s;
    logic               kill_r;
    logic               req_valid_r;
    logic [INSTR_W-1:0] instr_r;
    logic [WIDTH-1:0]   out_pc_r;
    logic               req_fire_s;
    logic               resp_take_s;

    pc_target #(.WIDTH(WIDTH)) u_pc_target (
        .pc             (pc_r),
        .redirect_valid (redirect_valid),
        .redirect_abs   (redirect_abs),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
        .next_pc        (next_pc_s)
    );

    // Handshake qualifiers and the redirect-masked decode valid.
    always_comb begin
        req_fire_s  = (state_r == REQ) && req_valid_r && imem_req_ready;
        resp_take_s = (state_r == WAIT) && imem_resp_valid && !kill_r && !redirect_valid;
        if_valid    = (state_r == OUT) && !redirect_valid;
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign if_instr       = instr_r;
    assign if_pc          = out_pc_r;

    // Sequencer FSM, PC, kill flag and decode buffer. The request valid is
    // registered, so halt is sampled the cycle before it takes effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            kill_r      <= 1'b0;
            req_valid_r <= 1'b0;
            instr_r     <= {INSTR_W{1'b0}};
            out_pc_r    <= {WIDTH{1'b0}};
        end else begin
            if (redirect_valid || resp_take_s) begin
                pc_r <= next_pc_s;
            end
            case (state_r)
                IDLE: begin
                    state_r     <= REQ;
                    req_valid_r <= !halt;
                end
                REQ: begin
                    if (req_fire_s) begin
                        // A redirect coincident with accept makes this fetch stale.
                        state_r     <= WAIT;
                        req_valid_r <= 1'b0;
                        kill_r      <= redirect_valid;
                    end else begin
                        req_valid_r <= !halt;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill_r || redirect_valid) begin
                            kill_r      <= 1'b0;
                            state_r     <= REQ;
                            req_valid_r <= !halt;
                        end else begin
                            instr_r  <= imem_resp_data;
                            out_pc_r <= pc_r;
                            state_r  <= OUT;
                        end
                    end else if (redirect_valid) begin
                        kill_r <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_valid || if_ready) begin
                        state_r     <= REQ;
                        req_valid_r <= !halt;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    kill_r      <= 1'b0;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table for the main
// flow and redirects, plus a hand sequence for reset-in-flight and PC wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        halt, req_ready, resp_valid, redir_valid, redir_abs, ifr;
    logic [31:0] resp_data, redir_base, redir_imm;
    logic        req_valid, if_valid;
    logic [31:0] req_addr, if_instr, if_pc;

    logic        w_req_ready, w_resp_valid, w_ifr;
    logic [31:0] w_resp_data;
    logic        w_req_valid, w_if_valid;
    logic [31:0] w_req_addr, w_if_instr, w_if_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] D = 32'hC0DE_0000;

    always #5 clk = ~clk;

    fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redir_valid), .redirect_abs(redir_abs),
        .redirect_base(redir_base), .redirect_imm(redir_imm),
        .if_valid(if_valid), .if_ready(ifr), .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .halt(1'b0),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(1'b0), .redirect_abs(1'b0),
        .redirect_base(32'h0000_0000), .redirect_imm(32'h0000_0000),
        .if_valid(w_if_valid), .if_ready(w_ifr), .if_instr(w_if_instr), .if_pc(w_if_pc)
    );

    typedef struct {
        string       name;
        logic        halt, rdy, rsp;
        logic [31:0] data;
        logic        redir, abs;
        logic [31:0] base, imm;
        logic        ifr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic h, logic r, logic s, logic [31:0] d,
                                logic rd, logic ab, logic [31:0] b, logic [31:0] im,
                                logic fr, logic erv, logic [31:0] ea, logic eiv,
                                logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.name = n; v.halt = h; v.rdy = r; v.rsp = s; v.data = d;
        v.redir = rd; v.abs = ab; v.base = b; v.imm = im; v.ifr = fr;
        v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_main(string n, logic erv, logic [31:0] ea, logic eiv,
                            logic [31:0] ep, logic [31:0] ei);
        chk({n, ".req_valid"}, {31'd0, req_valid}, {31'd0, erv});
        chk({n, ".req_addr"},  req_addr, ea);
        chk({n, ".if_valid"},  {31'd0, if_valid}, {31'd0, eiv});
        chk({n, ".if_pc"},     if_pc, ep);
        chk({n, ".if_instr"},  if_instr, ei);
    endtask

    task automatic chk_wrap(string n, logic erv, logic [31:0] ea, logic eiv,
                            logic [31:0] ep, logic [31:0] ei);
        chk({n, ".w_req_valid"}, {31'd0, w_req_valid}, {31'd0, erv});
        chk({n, ".w_req_addr"},  w_req_addr, ea);
        chk({n, ".w_if_valid"},  {31'd0, w_if_valid}, {31'd0, eiv});
        chk({n, ".w_if_pc"},     w_if_pc, ep);
        chk({n, ".w_if_instr"},  w_if_instr, ei);
    endtask

    task automatic idle_inputs();
        halt = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
        redir_valid = 1'b0; redir_abs = 1'b0; redir_base = 32'h0; redir_imm = 32'h0;
        ifr = 1'b0;
        w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 32'h0; w_ifr = 1'b0;
    endtask

    initial begin
        //          name       h  rdy rsp data            rd ab base          imm           ifr  rv addr          iv pc            instr
        tbl.push_back(mk("idle",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h0,       0,32'h0,       32'h0));
        tbl.push_back(mk("req0",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h0,       0,32'h0,       32'h0));
        tbl.push_back(mk("wait0",   0,1,1,D,              0,0,32'h0,       32'h0,       1,  0,32'h0,       0,32'h0,       32'h0));
        tbl.push_back(mk("out0",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h4,       1,32'h0,       D));
        tbl.push_back(mk("req4",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h4,       0,32'h0,       D));
        tbl.push_back(mk("wait4",   0,1,1,D+32'h4,        0,0,32'h0,       32'h0,       1,  0,32'h4,       0,32'h0,       D));
        tbl.push_back(mk("out4",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h8,       1,32'h4,       D+32'h4));
        tbl.push_back(mk("req8",    0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h8,       0,32'h4,       D+32'h4));
        tbl.push_back(mk("wait8",   0,1,1,D+32'h8,        0,0,32'h0,       32'h0,       1,  0,32'h8,       0,32'h4,       D+32'h4));
        tbl.push_back(mk("out8stl", 0,1,0,32'h0,          0,0,32'h0,       32'h0,       0,  0,32'hC,       1,32'h8,       D+32'h8));
        tbl.push_back(mk("out_rel", 0,1,0,32'h0,          1,0,32'h8,       32'hFFFFFFF8,1,  0,32'hC,       0,32'h8,       D+32'h8));
        tbl.push_back(mk("req_tgt0",0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h0,       0,32'h8,       D+32'h8));
        tbl.push_back(mk("wait_abs",0,1,1,32'hDEADBEEF,   1,1,32'h40,      32'h101,     1,  0,32'h0,       0,32'h8,       D+32'h8));
        tbl.push_back(mk("req_acc_r",0,1,0,32'h0,         1,0,32'h200,     32'h10,      1,  1,32'h100,     0,32'h8,       D+32'h8));
        tbl.push_back(mk("wait_kill",0,1,0,32'h0,         0,0,32'h0,       32'h0,       1,  0,32'h210,     0,32'h8,       D+32'h8));
        tbl.push_back(mk("wait_stale",0,1,1,32'hBAD00100, 0,0,32'h0,       32'h0,       1,  0,32'h210,     0,32'h8,       D+32'h8));
        tbl.push_back(mk("req210",  0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h210,     0,32'h8,       D+32'h8));
        tbl.push_back(mk("wait210", 0,1,1,D+32'h210,      0,0,32'h0,       32'h0,       1,  0,32'h210,     0,32'h8,       D+32'h8));
        tbl.push_back(mk("out210",  0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h214,     1,32'h210,     D+32'h210));
        tbl.push_back(mk("req214",  0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h214,     0,32'h210,     D+32'h210));
        tbl.push_back(mk("wait_hlt",1,1,1,D+32'h214,      0,0,32'h0,       32'h0,       1,  0,32'h214,     0,32'h210,     D+32'h210));
        tbl.push_back(mk("out_hlt", 1,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h218,     1,32'h214,     D+32'h214));
        tbl.push_back(mk("req_hlt_r",1,1,0,32'h0,         1,0,32'h300,     32'h4,       1,  0,32'h218,     0,32'h214,     D+32'h214));
        tbl.push_back(mk("req_unhlt",0,1,0,32'h0,         0,0,32'h0,       32'h0,       1,  0,32'h304,     0,32'h214,     D+32'h214));
        tbl.push_back(mk("req304",  0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  1,32'h304,     0,32'h214,     D+32'h214));
        tbl.push_back(mk("wait304", 0,1,0,32'h0,          0,0,32'h0,       32'h0,       1,  0,32'h304,     0,32'h214,     D+32'h214));

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_main("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("reset", 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            halt = tbl[i].halt; req_ready = tbl[i].rdy; resp_valid = tbl[i].rsp;
            resp_data = tbl[i].data; redir_valid = tbl[i].redir; redir_abs = tbl[i].abs;
            redir_base = tbl[i].base; redir_imm = tbl[i].imm; ifr = tbl[i].ifr;
            #1;
            chk_main(tbl[i].name, tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
                     tbl[i].e_pc, tbl[i].e_instr);
            @(negedge clk);
        end

        // Reset while the main instance waits on a fetch.
        idle_inputs();
        rst = 1'b0;
        #1;
        chk_main("rst_mid_wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("rst_wrap", 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // c0: late response arrives in IDLE; wrap instance in IDLE.
        resp_valid = 1'b1; resp_data = 32'hBAD0BAD0;
        w_req_ready = 1'b1; w_ifr = 1'b1;
        #1;
        chk_main("late_c0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("wrap_c0", 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        // c1: first requests issue; main memory not ready.
        #1;
        chk_main("late_c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("wrap_c1", 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        // c2: wrap response.
        resp_valid = 1'b0;
        w_resp_valid = 1'b1; w_resp_data = 32'h1234_5678;
        #1;
        chk_main("late_c2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("wrap_c2", 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        // c3: wrap delivers; PC has wrapped to zero.
        w_resp_valid = 1'b0;
        #1;
        chk_main("late_c3", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_wrap("wrap_c3", 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h1234_5678);
        @(negedge clk);
        // c4: next wrap request at zero.
        #1;
        chk_wrap("wrap_c4", 1'b1, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h1234_5678);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake for the RISC-V core. It computes sequential and redirect targets (PC-relative branch and absolute jump), keeps one fetch in flight, and hands instructions to decode over a valid/ready port. It kills stale fetches after a redirect. It sits between the instruction memory and the decode stage and replaces free-running PC stepping with stall-aware sequencing.

## Interface
- WIDTH, 32, PC/address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- halt  in  1  suppress new fetch requests while 1
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WIDTH  fetch address
- imem_resp_valid  in  1  fetch data valid; earliest one cycle after accept
- imem_resp_data  in  32  fetched instruction
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_abs  in  1  1 = absolute jump target, 0 = PC-relative
- redirect_base  in  WIDTH  PC of the redirecting instruction
- redirect_imm  in  WIDTH  offset (relative) or full target (absolute)
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  instruction
- if_pc  out  WIDTH  PC of if_instr

## Operation
- Target: relative = redirect_base + redirect_imm, mod 2^WIDTH; absolute = {redirect_imm[WIDTH-1:1],1'b0}. No alignment trap. Bit 1 is passed through unchanged.
- Sequential: pc + 4, wrapping from 2^WIDTH-4 to 0.
- FSM states:
  - IDLE: one cycle after reset, then go to REQ.
  - REQ: imem_req_valid = !halt, imem_req_addr = pc. On valid&ready, go to WAIT.
  - WAIT: wait for imem_resp_valid.
    - kill=0: latch data and pc into the output buffer, pc += 4, go to OUT.
    - kill=1: drop the data, clear kill, go to REQ.
  - OUT: if_valid=1. On if_valid&if_ready, go to REQ.
- Redirect (redirect_valid=1) always wins; pc <= target in every state.
  - REQ without accept: go to the new address. The request address may change only on a redirect.
  - REQ with accept in the same cycle: the accepted fetch is stale. Set kill, go to WAIT.
  - WAIT: set kill. A response arriving in the same cycle is dropped, go to REQ; otherwise stay in WAIT.
  - OUT: discard the buffer, go to REQ. if_valid = (state==OUT) & !redirect_valid, so no handshake completes that cycle.
  - IDLE: pc <= target, proceed to REQ.
- halt affects only REQ issue. An outstanding fetch completes and the buffered instruction is still delivered.
- At most one outstanding memory request.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, kill=0, imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0. imem_req_addr shows pc.
- Reset may assert in any state. It clears the FSM immediately. An in-flight response arriving after release is ignored, because the FSM is not in WAIT.
- First request: imem_req_valid=1 in the second cycle after rst deassertion (IDLE then REQ).
- Best-case throughput is 3 cycles per instruction: REQ accept, response in WAIT, decode handshake in OUT.
- Redirect-to-request latency: the new address appears on imem_req_addr in the cycle after redirect_valid. In REQ without accept, it appears in the same cycle as the registered pc update, i.e. the next cycle.
- All outputs are registered except if_valid, which is masked combinationally by redirect_valid.

## Structure
- Package fetch_pkg:
  - state enum {IDLE, REQ, WAIT, OUT}
  - INSTR_W=32
  - PC_INC=4
  - default RESET_PC
- Sub-module pc_target: combinational redirect/sequential target select (adder plus absolute-mask mux), reused by later branch-prediction work.
- Top: FSM, pc register, kill flag, output buffer.

## Test plan
- Reset release, memory always ready, response one cycle later, decode always ready:
  - addresses 0x0, 0x4, 0x8 issued.
  - if_pc/if_instr match, one instruction every 3 cycles.
- Relative redirect in OUT with base=0x8, imm=0xFFFFFFF8:
  - buffer dropped, if_valid low that cycle.
  - next request addr=0x0.
- Absolute redirect in WAIT with imm=0x101, response in the same cycle:
  - response dropped, next addr=0x100, no instruction delivered from the old fetch.
- Redirect in REQ coincident with accept, response 2 cycles later:
  - stale response dropped, then request to the target.
- Wrap and halt:
  - RESET_PC=0xFFFFFFFC: fetch at 0xFFFFFFFC, then 0x0.
  - halt raised in WAIT: the instruction is delivered, then imem_req_valid stays 0 until halt falls.
- rst asserted mid-WAIT, late response arriving after release:
  - ignored, first request to RESET_PC.
